seq_gen: RTL and testbench

SEQ_GEN -- requirements
Module: seq_gen

---
 rtl/seq_gen_pkg.sv | 19 +
 rtl/seq_gen_if.sv | 27 ++
 rtl/seq_gen_shift.sv | 61 ++++++
 rtl/seq_gen.sv | 126 ++++++++++++
 tb/tb_seq_gen.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_pkg;

    localparam int PAT_W_DEF = 8;   // default pattern register width
    localparam int GAP_DEF   = 1;   // default idle cycles between repetitions
    localparam int CNT_W     = 4;   // width of len / reps / index / gap counters

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        GAP_ST = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/seq_gen_if.sv
// Request/stream bundle between a pattern requester and seq_gen.
// Latency: n/a (wires only).
// Backpressure: none; start is a request sampled only while the generator is idle.
//   master: drives start/pattern/len/reps, observes dout/valid/busy/done
//   slave : the generator itself
interface seq_gen_if import seq_pkg::*; #(
    parameter int PAT_W = PAT_W_DEF
) ();
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] reps;
    logic             dout;
    logic             valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, len, reps,
        input  dout, valid, busy, done
    );

    modport slave (
        input  start, pattern, len, reps,
        output dout, valid, busy, done
    );
endinterface

// File: rtl/seq_gen_shift.sv
// Captured pattern register plus MSB-first bit-index down-counter.
// Latency: next_bit_o is the bit selected by the index value taking effect at the next edge.
// Backpressure: none; load has priority over reload, reload over decrement.
//   clk_i/rst_i        : clock, synchronous active-high reset (clears pattern, len, index)
//   load_i/pat_i/len_i : capture a new pattern and length, index <- len-1
//   reload_i           : index <- captured len-1 (start of next repetition)
//   dec_i              : index <- index-1
//   next_bit_o         : pattern bit at the upcoming index (feeds the registered dout)
//   idx_zero_o         : current index is 0 (last bit of a repetition on the line)
module seq_gen_shift import seq_pkg::*; #(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [PAT_W-1:0] pat_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             reload_i,
    input  logic             dec_i,
    output logic             next_bit_o,
    output logic             idx_zero_o
);

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [PAT_W-1:0] shifted;

    always_comb begin
        pat_d = pat_q;
        len_d = len_q;
        idx_d = idx_q;
        if (load_i) begin
            pat_d = pat_i;
            len_d = len_i;
            idx_d = len_i - CNT_ONE;
        end else if (reload_i) begin
            idx_d = len_q - CNT_ONE;
        end else if (dec_i) begin
            idx_d = idx_q - CNT_ONE;
        end
        // Select via shift so the index width need not match log2(PAT_W).
        shifted    = pat_d >> idx_d;
        next_bit_o = shifted[0];
    end

    assign idx_zero_o = (idx_q == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pat_q <= '0;
            len_q <= '0;
            idx_q <= '0;
        end else begin
            pat_q <= pat_d;
            len_q <= len_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/seq_gen.sv
// Serial pattern generator: sends len bits of pattern MSB-first, reps times, GAP idle cycles apart.
// Latency: first bit on dout one cycle after the accepting edge; done after reps*len+(reps-1)*GAP+1 cycles.
// Backpressure: none; start outside IDLE (or with illegal len/reps) is dropped, never queued.
//   clock : single clock, rising edge
//   reset : synchronous active-high; wins over start
//   bus   : start/pattern/len/reps in; dout/valid/busy/done out (all registered)
module seq_gen import seq_pkg::*; #(
    parameter int PAT_W = PAT_W_DEF,
    parameter int GAP   = GAP_DEF
) (
    input  logic       clock,
    input  logic       reset,
    seq_gen_if.slave   bus
);

    localparam logic [CNT_W-1:0] LEN_MAX  = CNT_W'(PAT_W);
    localparam logic [CNT_W-1:0] GAP_LAST = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] reps_q, reps_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic             dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept;
    logic             load, reload, dec;
    logic             next_bit, idx_zero;

    seq_gen_shift #(.PAT_W(PAT_W)) u_shift (
        .clk_i      (clock),
        .rst_i      (reset),
        .load_i     (load),
        .pat_i      (bus.pattern),
        .len_i      (bus.len),
        .reload_i   (reload),
        .dec_i      (dec),
        .next_bit_o (next_bit),
        .idx_zero_o (idx_zero)
    );

    assign accept = bus.start && (bus.len != '0) && (bus.len <= LEN_MAX) && (bus.reps != '0);

    always_comb begin
        state_d = state_q;
        reps_d  = reps_q;
        gap_d   = gap_q;
        load    = 1'b0;
        reload  = 1'b0;
        dec     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    load    = 1'b1;
                    reps_d  = bus.reps;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (!idx_zero) begin
                    dec = 1'b1;
                end else if (reps_q > CNT_ONE) begin
                    reps_d = reps_q - CNT_ONE;
                    if (GAP > 0) begin
                        state_d = GAP_ST;
                        gap_d   = GAP_LAST;
                    end else begin
                        reload = 1'b1;   // back-to-back repetition
                    end
                end else begin
                    state_d = DONE;
                end
            end
            GAP_ST: begin
                // gap_q counts down from GAP-1, so this state lasts exactly GAP cycles.
                if (gap_q == '0) begin
                    reload  = 1'b1;
                    state_d = SEND;
                end else begin
                    gap_d = gap_q - CNT_ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are computed from the next state so they appear registered
        // in the same cycle the FSM occupies that state.
        dout_d  = (state_d == SEND) && next_bit;
        valid_d = (state_d == SEND);
        busy_d  = (state_d == SEND) || (state_d == GAP_ST);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            reps_q  <= '0;
            gap_q   <= '0;
            dout_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            reps_q  <= reps_d;
            gap_q   <= gap_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.dout  = dout_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen (PAT_W=8, GAP=1).
// Expected streams are hand-written strings, one character per cycle after the accepting edge:
//   '1'/'0' pattern bit with valid, 'g' gap cycle, 'D' done pulse, 'i' idle.
module tb_seq_gen;
    import seq_pkg::*;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    seq_gen_if #(.PAT_W(8)) bus ();

    seq_gen #(.PAT_W(8), .GAP(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [7:0]  pat;
        logic [3:0]  len;
        logic [3:0]  reps;
        int          poke;   // cycle after which a competing start is pulsed (0 = none)
        string       exp;
        logic [15:0] det;    // cycles at which a "101" detector on the stream fires
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [3:0] exp_of(byte c);
        case (c)
            "1":     return 4'b1110;
            "0":     return 4'b0110;
            "g":     return 4'b0010;
            "D":     return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic check(string nm, logic [3:0] want);
        logic [3:0] act;
        act = {bus.dout, bus.valid, bus.busy, bus.done};
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: dout/valid/busy/done got %b want %b", nm, act, want);
        end
    endtask

    task automatic run_vec(vec_t v);
        logic [2:0]  hist;
        logic [15:0] mask;
        hist = 3'b000;
        mask = '0;
        @(posedge clock); #1;
        bus.start   = 1'b1;
        bus.pattern = v.pat;
        bus.len     = v.len;
        bus.reps    = v.reps;
        for (int k = 1; k <= v.exp.len(); k++) begin
            @(posedge clock); #1;
            bus.start = 1'b0;
            if (k == 1) begin
                // Inputs change after acceptance; the stream must not follow them.
                bus.pattern = ~v.pat;
                bus.len     = 4'd2;
                bus.reps    = 4'd9;
            end
            check($sformatf("%s c%0d", v.name, k), exp_of(v.exp[k-1]));
            if (bus.valid) begin
                hist = {hist[1:0], bus.dout};
                if (hist == 3'b101) mask[k] = 1'b1;
            end
            if (k == v.poke) begin
                bus.start   = 1'b1;
                bus.pattern = 8'hFF;
                bus.len     = 4'd8;
                bus.reps    = 4'd3;
            end
        end
        bus.start = 1'b0;
        n_cmp++;
        if (mask !== v.det) begin
            n_err++;
            $display("FAIL %s det: positions got %h want %h", v.name, mask, v.det);
        end
    endtask

    initial begin
        vecs.push_back('{"p05_l3_r1",   8'h05, 4'd3,  4'd1, 0, "101Di",         16'h0008});
        vecs.push_back('{"p05_l3_r2",   8'h05, 4'd3,  4'd2, 0, "101g101Di",     16'h0088});
        vecs.push_back('{"pA5_l8_r1",   8'hA5, 4'd8,  4'd1, 0, "10100101Di",    16'h0108});
        vecs.push_back('{"pF0_l1_r3",   8'hF0, 4'd1,  4'd3, 0, "0g0g0Di",       16'h0000});
        vecs.push_back('{"p3C_l4_r2",   8'h3C, 4'd4,  4'd2, 0, "1100g1100Di",   16'h0000});
        vecs.push_back('{"p81_l8_r1",   8'h81, 4'd8,  4'd1, 0, "10000001Di",    16'h0000});
        vecs.push_back('{"len0",        8'h05, 4'd0,  4'd1, 0, "iiii",          16'h0000});
        vecs.push_back('{"len9",        8'h05, 4'd9,  4'd1, 0, "iiii",          16'h0000});
        vecs.push_back('{"len15",       8'hFF, 4'd15, 4'd1, 0, "iii",           16'h0000});
        vecs.push_back('{"reps0",       8'h05, 4'd3,  4'd0, 0, "iiii",          16'h0000});
        vecs.push_back('{"poke_send",   8'h05, 4'd3,  4'd1, 2, "101Diii",       16'h0008});
        vecs.push_back('{"poke_gap",    8'h05, 4'd3,  4'd2, 4, "101g101Dii",    16'h0088});
        vecs.push_back('{"poke_done",   8'h05, 4'd3,  4'd1, 4, "101Dii",        16'h0008});

        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.pattern = '0;
        bus.len     = '0;
        bus.reps    = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", 4'b0000);
        reset = 1'b0;
        @(posedge clock); #1;
        check("idle_after_reset", 4'b0000);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during the second bit of a len=8 transmission, with start held alongside it.
        @(posedge clock); #1;
        bus.start   = 1'b1;
        bus.pattern = 8'hA5;
        bus.len     = 4'd8;
        bus.reps    = 4'd1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        check("midrst_bit1", 4'b1110);
        @(posedge clock); #1;
        check("midrst_bit2", 4'b0110);
        reset       = 1'b1;
        bus.start   = 1'b1;
        bus.pattern = 8'h05;
        bus.len     = 4'd3;
        bus.reps    = 4'd1;
        @(posedge clock); #1;
        check("midrst_cleared", 4'b0000);
        @(posedge clock); #1;
        check("rst_over_start", 4'b0000);
        reset     = 1'b0;
        bus.start = 1'b0;
        @(posedge clock); #1;
        check("post_rst_idle", 4'b0000);
        run_vec('{"post_rst_A5", 8'hA5, 4'd8, 4'd1, 0, "10100101Di", 16'h0108});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
